// File: rtl/uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_arbiter
// Brief    : Two-requester packet arbiter feeding a single uart_tx byte port.
//            Optional idle-owner timeout enabled by macro UART_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       uart_ready,
  output logic [7:0] uart_out,
  output logic       uart_out_en,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t     state_q;
  logic       owner_q;      // 0: req0 owns the lock, 1: req1
  logic       ptr_q;        // requester favoured on the next tie
  logic       last_q;
  logic [1:0] grant_q;
  logic [7:0] out_q;
  logic       out_en_q;
  logic       rdy0_q;
  logic       rdy1_q;

  logic       owner_valid;
  logic [7:0] owner_data;
  logic       owner_last;

  assign owner_valid = owner_q ? req1_valid : req0_valid;
  assign owner_data  = owner_q ? req1_data  : req0_data;
  assign owner_last  = owner_q ? req1_last  : req0_last;

`ifdef UART_ARBITER_TIMEOUT_EN
  logic [15:0] idle_cnt_q;
  logic        timeout_q;
  assign timeout_pulse = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_pulse      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      ptr_q      <= 1'b0;
      last_q     <= 1'b0;
      grant_q    <= 2'b00;
      out_q      <= 8'h00;
      out_en_q   <= 1'b0;
      rdy0_q     <= 1'b0;
      rdy1_q     <= 1'b0;
`ifdef UART_ARBITER_TIMEOUT_EN
      idle_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      out_en_q  <= 1'b0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
`ifdef UART_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req0_valid || req1_valid) state_q <= S_ARB;
        end
        S_ARB: begin
          if (req0_valid && (!req1_valid || !ptr_q)) begin
            owner_q <= 1'b0;
            grant_q <= 2'b01;
            state_q <= S_WAIT;
          end else if (req1_valid) begin
            owner_q <= 1'b1;
            grant_q <= 2'b10;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          // Strobe and handshake are registered here so they appear together in ISSUE.
          if (owner_valid && uart_ready) begin
            out_q    <= owner_data;
            last_q   <= owner_last;
            out_en_q <= 1'b1;
            rdy0_q   <= ~owner_q;
            rdy1_q   <= owner_q;
            state_q  <= S_ISSUE;
          end
`ifdef UART_ARBITER_TIMEOUT_EN
          if (owner_valid) begin
            idle_cnt_q <= 16'd0;
          end else if (({1'b0, idle_cnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES}) begin
            idle_cnt_q <= 16'd0;
            grant_q    <= 2'b00;
            ptr_q      <= ~owner_q;
            timeout_q  <= 1'b1;
            state_q    <= S_IDLE;
          end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
`endif
        end
        S_ISSUE: begin
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (last_q) begin
            grant_q <= 2'b00;
            ptr_q   <= ~owner_q;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = rdy0_q;
  assign req1_ready  = rdy1_q;
  assign uart_out    = out_q;
  assign uart_out_en = out_en_q;
  assign grant       = grant_q;

endmodule
`default_nettype wire

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd4095: idle cycles a locked owner may stall before forced release.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a byte.
REQ-005 req0_data  input  8  requester 0 byte.
REQ-006 req0_last  input  1  byte is final byte of requester 0 packet.
REQ-007 req0_ready  output  1  one-cycle pulse: requester 0 byte taken.
REQ-008 req1_valid / req1_data / req1_last / req1_ready  same widths and directions as REQ-004..007, for requester 1.
REQ-009 uart_ready  input  1  uart_tx idle and able to accept a byte.
REQ-010 uart_out  output  8  byte to uart_tx.
REQ-011 uart_out_en  output  1  one-cycle write strobe to uart_tx.
REQ-012 grant  output  2  one-hot current packet owner; 2'b00 when unlocked.
REQ-013 timeout_pulse  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states: IDLE, ARB, ISSUE, HOLD, WAIT; a packet is never interleaved with the other requester's bytes.
REQ-015 IDLE: if req0_valid or req1_valid, go to ARB next cycle.
REQ-016 ARB: pick owner; if only one valid, that one wins; if both valid, the requester not served on the previous completed packet wins; after reset, req0 wins ties; set grant; go to WAIT.
REQ-017 WAIT: when uart_ready=1 and owner valid=1, go to ISSUE; when owner valid=0, stay and count the idle cycle.
REQ-018 ISSUE, one cycle: uart_out<=owner data, uart_out_en=1, owner req_ready=1 in this same cycle; latch owner last; go to HOLD.
REQ-019 HOLD, exactly one cycle, ignores uart_ready (uart_tx deasserts ready within 1 cycle of write); then go to IDLE with grant cleared if latched last=1, else WAIT.
REQ-020 Best-case packet-start latency: valid rises in cycle N with uart_ready=1 gives uart_out_en in cycle N+3; back-to-back bytes within a packet at most every 3 cycles, otherwise paced by uart_ready.
REQ-021 Non-owner req_ready stays 0 for the whole packet; non-owner valid is ignored until grant clears.
REQ-022 Owner valid dropping mid-packet keeps the lock; no bytes are issued from the other requester.
REQ-023 Round-robin pointer flips only on completed (last=1) or forced-released packets, to the non-served requester.
REQ-024 uart_out holds its last value outside ISSUE; uart_out_en and req*_ready are 0 in every state except ISSUE.
REQ-025 At most one of req0_ready, req1_ready is high in any cycle; grant is never 2'b11.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, grant=2'b00, uart_out=8'h00, uart_out_en=0, req0_ready=0, req1_ready=0, timeout_pulse=0, pointer favours req0, timeout counter=0.
REQ-027 Reset mid-packet aborts the packet without further uart_out_en; the next packet after reset starts fresh arbitration.

Configuration
REQ-028 Macro UART_ARBITER_TIMEOUT_EN defined: WAIT counts consecutive cycles with owner valid=0, saturating; the counter clears on owner valid=1 or ISSUE.
REQ-029 With the macro defined, when the count reaches TIMEOUT_CYCLES: grant cleared, timeout_pulse=1 for one cycle, pointer flips, state to IDLE.
REQ-030 Macro undefined: no counter logic, timeout_pulse tied 0, lock held indefinitely until last byte.

Verification
REQ-031 req0 sends 3 bytes 8'h41,8'h42,8'h43 (last on 8'h43), uart_ready always 1 -> uart_out_en in cycles N+3, N+6, N+9, each with req0_ready pulse; grant=2'b01 until last, then 2'b00.
REQ-032 req0 and req1 both valid in the same cycle after reset, 2-byte packets -> req0 packet fully issued first, then req1; next simultaneous request -> req0 wins again only after req1 has been served.
REQ-033 req1 valid while req0 packet mid-flight with req0 valid low 10 cycles -> no req1 byte issued; req0 completes, then req1 granted.
REQ-034 uart_ready held 0 for 50 cycles after first byte -> second byte strobed no earlier than 1 cycle after uart_ready returns 1; no strobe while uart_ready=0 outside HOLD.
REQ-035 Macro defined, TIMEOUT_CYCLES=16: owner stalls mid-packet -> timeout_pulse after 16 idle cycles, grant=2'b00, waiting req1 granted next.
REQ-036 rst asserted during HOLD of a 4-byte packet -> all outputs at reset values next cycle, no further uart_out_en until a new request arrives.
